ds_operand_stage: RTL

- Decode-side operand stage, directly upstream of the register file.
- Holds the fetch-to-decode pipeline register and extracts source register numbers from the instruction.
- Drives the register file's two asynchronous read ports.
- Resolves RAW hazards by forwarding from the EX/MEM/WB stages, or by stalling on load-use; hands operands to EX with a valid/allowin handshake.

---
 rtl/ds_operand_stage_pkg.sv | 34 +++
 rtl/ds_operand_stage_if.sv | 64 ++++++
 rtl/ds_operand_stage_operand_fwd_mux.sv | 39 +++
 rtl/ds_operand_stage.sv | 105 ++++++++++
 4 files changed

// File: rtl/ds_operand_stage_pkg.sv
// Shared constants and types for the decode-side operand stage.
// The bypass bus is a single struct so EX/MEM/WB can be handled uniformly.
package ds_operand_stage_pkg;

  localparam int DS_DATA_W = 32;
  localparam int DS_REG_AW = 5;
  localparam int NUM_FWD   = 3;

  // Instruction field positions.
  localparam int RJ_LSB = 5;
  localparam int RK_LSB = 10;
  localparam int RD_LSB = 0;

  localparam logic [DS_REG_AW-1:0] REG_ZERO = '0;

  // Index order inside a bypass array is also the forwarding priority.
  localparam int FWD_ES = 0;
  localparam int FWD_MS = 1;
  localparam int FWD_WS = 2;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [DS_REG_AW-1:0] dest;
    logic [DS_DATA_W-1:0] data;
    logic                 is_load;
  } fwd_bus_t;

  function automatic logic [DS_REG_AW-1:0] reg_field(input logic [DS_DATA_W-1:0] inst,
                                                     input int lsb);
    return inst[lsb +: DS_REG_AW];
  endfunction

endpackage

// File: rtl/ds_operand_stage_if.sv
// Fetch, regfile, bypass and EX-side signals of the operand stage.
// master = surrounding pipeline, slave = the operand stage itself.
interface ds_operand_stage_if #(
  parameter int DATA_W = ds_operand_stage_pkg::DS_DATA_W,
  parameter int REG_AW = ds_operand_stage_pkg::DS_REG_AW
);
  logic              fs_to_ds_valid;
  logic              ds_allowin;
  logic [DATA_W-1:0] fs_pc;
  logic [DATA_W-1:0] fs_inst;
  logic              fs_src1_en;
  logic              fs_src2_en;
  logic              fs_src2_is_rd;

  logic [REG_AW-1:0] rf_raddr1;
  logic [DATA_W-1:0] rf_rdata1;
  logic [REG_AW-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata2;

  logic              es_fwd_valid;
  logic              es_fwd_we;
  logic              es_fwd_is_load;
  logic [REG_AW-1:0] es_fwd_dest;
  logic [DATA_W-1:0] es_fwd_data;
  logic              ms_fwd_valid;
  logic              ms_fwd_we;
  logic [REG_AW-1:0] ms_fwd_dest;
  logic [DATA_W-1:0] ms_fwd_data;
  logic              ws_fwd_valid;
  logic              ws_fwd_we;
  logic [REG_AW-1:0] ws_fwd_dest;
  logic [DATA_W-1:0] ws_fwd_data;

  logic              es_allowin;
  logic              flush;
  logic              ds_to_es_valid;
  logic [DATA_W-1:0] ds_pc;
  logic [DATA_W-1:0] ds_inst;
  logic [DATA_W-1:0] ds_src1;
  logic [DATA_W-1:0] ds_src2;
  logic [31:0]       ds_stall_cnt;

  modport master (
    output fs_to_ds_valid, fs_pc, fs_inst, fs_src1_en, fs_src2_en, fs_src2_is_rd,
    output rf_rdata1, rf_rdata2,
    output es_fwd_valid, es_fwd_we, es_fwd_is_load, es_fwd_dest, es_fwd_data,
    output ms_fwd_valid, ms_fwd_we, ms_fwd_dest, ms_fwd_data,
    output ws_fwd_valid, ws_fwd_we, ws_fwd_dest, ws_fwd_data,
    output es_allowin, flush,
    input  ds_allowin, rf_raddr1, rf_raddr2,
    input  ds_to_es_valid, ds_pc, ds_inst, ds_src1, ds_src2, ds_stall_cnt
  );

  modport slave (
    input  fs_to_ds_valid, fs_pc, fs_inst, fs_src1_en, fs_src2_en, fs_src2_is_rd,
    input  rf_rdata1, rf_rdata2,
    input  es_fwd_valid, es_fwd_we, es_fwd_is_load, es_fwd_dest, es_fwd_data,
    input  ms_fwd_valid, ms_fwd_we, ms_fwd_dest, ms_fwd_data,
    input  ws_fwd_valid, ws_fwd_we, ws_fwd_dest, ws_fwd_data,
    input  es_allowin, flush,
    output ds_allowin, rf_raddr1, rf_raddr2,
    output ds_to_es_valid, ds_pc, ds_inst, ds_src1, ds_src2, ds_stall_cnt
  );
endinterface

// File: rtl/ds_operand_stage_operand_fwd_mux.sv
// One source operand: bypass match per stage and EX > MEM > WB > regfile select.
// load_hit_o flags that the winning bypass is a load whose data is not ready yet.
module operand_fwd_mux
  import ds_operand_stage_pkg::*;
(
  input  logic                 src_en_i,
  input  logic [DS_REG_AW-1:0] raddr_i,
  input  logic [DS_DATA_W-1:0] rf_rdata_i,
  input  fwd_bus_t             byp_i [NUM_FWD],
  output logic [DS_DATA_W-1:0] operand_o,
  output logic                 load_hit_o
);

  logic [NUM_FWD-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
      assign hit[gi] = byp_i[gi].valid & byp_i[gi].we & (byp_i[gi].dest == raddr_i) &
                       (raddr_i != REG_ZERO) & src_en_i;
    end
  endgenerate

  // Walk from lowest to highest priority so the youngest producer wins.
  always_comb begin
    operand_o  = rf_rdata_i;
    load_hit_o = 1'b0;
    if (!src_en_i || raddr_i == REG_ZERO) begin
      operand_o = '0;
    end else begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (hit[k]) begin
          operand_o  = byp_i[k].data;
          load_hit_o = byp_i[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/ds_operand_stage.sv
// Decode operand stage: fetch->decode register, regfile read addressing,
// EX/MEM/WB forwarding and load-use stall with a valid/allowin handshake.
module ds_operand_stage
  import ds_operand_stage_pkg::*;
#(
  parameter int DATA_W = DS_DATA_W,
  parameter int REG_AW = DS_REG_AW
) (
  input  logic clk,
  input  logic reset,
  ds_operand_stage_if.slave bus
);

  logic              ds_valid_q;
  logic [DATA_W-1:0] ds_pc_q;
  logic [DATA_W-1:0] ds_inst_q;
  logic              src1_en_q;
  logic              src2_en_q;
  logic              src2_is_rd_q;
  logic [31:0]       stall_cnt_q;
  logic [31:0]       stall_cnt_d;

  logic              src_en    [2];
  logic [REG_AW-1:0] raddr     [2];
  logic [DATA_W-1:0] rf_rdata  [2];
  logic [DATA_W-1:0] operand   [2];
  logic              load_hit  [2];
  fwd_bus_t          byp       [NUM_FWD];

  logic load_use;
  logic ds_ready_go;
  logic ds_allowin;

  // Only EX can still hold a load whose data is not yet available.
  assign byp[FWD_ES] = '{valid: bus.es_fwd_valid, we: bus.es_fwd_we, dest: bus.es_fwd_dest,
                         data: bus.es_fwd_data, is_load: bus.es_fwd_is_load};
  assign byp[FWD_MS] = '{valid: bus.ms_fwd_valid, we: bus.ms_fwd_we, dest: bus.ms_fwd_dest,
                         data: bus.ms_fwd_data, is_load: 1'b0};
  assign byp[FWD_WS] = '{valid: bus.ws_fwd_valid, we: bus.ws_fwd_we, dest: bus.ws_fwd_dest,
                         data: bus.ws_fwd_data, is_load: 1'b0};

  assign src_en[0]   = src1_en_q;
  assign src_en[1]   = src2_en_q;
  assign raddr[0]    = reg_field(ds_inst_q, RJ_LSB);
  assign raddr[1]    = src2_is_rd_q ? reg_field(ds_inst_q, RD_LSB) : reg_field(ds_inst_q, RK_LSB);
  assign rf_rdata[0] = bus.rf_rdata1;
  assign rf_rdata[1] = bus.rf_rdata2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      operand_fwd_mux u_mux (
        .src_en_i   (src_en[gi]),
        .raddr_i    (raddr[gi]),
        .rf_rdata_i (rf_rdata[gi]),
        .byp_i      (byp),
        .operand_o  (operand[gi]),
        .load_hit_o (load_hit[gi])
      );
    end
  endgenerate

  assign load_use    = ds_valid_q & (load_hit[0] | load_hit[1]);
  assign ds_ready_go = !load_use;
  assign ds_allowin  = !ds_valid_q | (ds_ready_go & bus.es_allowin);
  assign stall_cnt_d = (load_use && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1
                                                                 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q   <= 1'b0;
      ds_pc_q      <= '0;
      ds_inst_q    <= '0;
      src1_en_q    <= 1'b0;
      src2_en_q    <= 1'b0;
      src2_is_rd_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      // Flush kills the held instruction even while it is stalled.
      if (bus.flush) begin
        ds_valid_q <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid_q <= bus.fs_to_ds_valid;
      end
      if (bus.fs_to_ds_valid && ds_allowin) begin
        ds_pc_q      <= bus.fs_pc;
        ds_inst_q    <= bus.fs_inst;
        src1_en_q    <= bus.fs_src1_en;
        src2_en_q    <= bus.fs_src2_en;
        src2_is_rd_q <= bus.fs_src2_is_rd;
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.ds_allowin     = ds_allowin;
  assign bus.ds_to_es_valid = ds_valid_q & ds_ready_go & !bus.flush;
  assign bus.rf_raddr1      = raddr[0];
  assign bus.rf_raddr2      = raddr[1];
  assign bus.ds_pc          = ds_pc_q;
  assign bus.ds_inst        = ds_inst_q;
  assign bus.ds_src1        = operand[0];
  assign bus.ds_src2        = operand[1];
  assign bus.ds_stall_cnt   = stall_cnt_q;

endmodule
